// File: rtl/tx_iod_train_gen.sv
// tx_iod_train_gen
// Transmit-side lane word generator for an 8:1 TX IOD lane. Sends a fixed
// training pattern until the far-end receiver reports bit alignment, then
// carries user words through a valid/ready handshake or a PRBS7 test stream.
// TX_DATA bit 0 is the first bit on the wire.

module tx_iod_train_gen #(
  parameter logic [7:0]  TRAIN_PATTERN    = 8'hF0,
  parameter logic [7:0]  IDLE_WORD        = 8'hA5,
  parameter int unsigned TRAIN_CYCLES_MIN = 256,
  parameter logic [6:0]  PRBS_SEED        = 7'h7F
) (
  input  logic       FAB_CLK,
  input  logic       TX_SYNC_RST,
  input  logic       TRAIN_REQ,
  input  logic       ALIGN_DONE,
  input  logic       PRBS_EN,
  input  logic [7:0] USER_DATA,
  input  logic       USER_VALID,
  output logic       USER_READY,
  output logic [7:0] TX_DATA,
  output logic [3:0] OE_DATA,
  output logic [1:0] STATE,
  output logic       TRAINED
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DATA  = 2'd2,
    ST_PRBS  = 2'd3
  } state_t;

  // Counter is wide enough to hold TRAIN_CYCLES_MIN itself, where it saturates.
  localparam int CNT_W = $clog2(TRAIN_CYCLES_MIN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TRAIN_CYCLES_MIN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] train_cnt;
  logic [6:0]       lfsr;

  logic [7:0] word_from_lfsr;
  logic [6:0] lfsr_after;
  logic [7:0] word_from_seed;
  logic [6:0] seed_after;

  // Runs the x^7+x^6+1 generator for eight steps. The first step's output
  // lands in bit 0 so it is serialized first. Returns {next_state, word}.
  function automatic logic [14:0] prbs_step8(input logic [6:0] start);
    logic [6:0] s;
    logic [7:0] w;
    s = start;
    w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w[i] = s[6];
      s    = {s[5:0], s[6] ^ s[5]};
    end
    return {s, w};
  endfunction

  assign {lfsr_after, word_from_lfsr} = prbs_step8(lfsr);
  assign {seed_after, word_from_seed} = prbs_step8(PRBS_SEED);

  assign STATE = state_q;

  // Words are only taken while carrying user data and no retrain is pending.
  assign USER_READY = (state_q == ST_DATA) && !TRAIN_REQ;

  // Lane FSM: state, outgoing word, output enable, trained flag, training
  // counter and PRBS generator all advance together on one edge.
  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      state_q   <= ST_IDLE;
      TX_DATA   <= 8'h00;
      OE_DATA   <= 4'b0000;
      TRAINED   <= 1'b0;
      train_cnt <= '0;
      lfsr      <= PRBS_SEED;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (TRAIN_REQ) begin
            state_q   <= ST_TRAIN;
            TX_DATA   <= TRAIN_PATTERN;
            OE_DATA   <= 4'b1111;
            TRAINED   <= 1'b0;
            train_cnt <= CNT_ONE;
          end else begin
            TX_DATA <= 8'h00;
            OE_DATA <= 4'b0000;
            TRAINED <= 1'b0;
          end
        end

        ST_TRAIN: begin
          OE_DATA <= 4'b1111;
          if ((train_cnt == CNT_MAX) && ALIGN_DONE && !TRAIN_REQ) begin
            TRAINED <= 1'b1;
            if (PRBS_EN) begin
              // First PRBS word comes straight from the seed so the far end
              // sees a known stream immediately after the last pattern word.
              state_q <= ST_PRBS;
              TX_DATA <= word_from_seed;
              lfsr    <= seed_after;
            end else begin
              // No word could have been accepted in TRAIN, so DATA opens
              // with the fill word.
              state_q <= ST_DATA;
              TX_DATA <= IDLE_WORD;
            end
          end else begin
            TX_DATA <= TRAIN_PATTERN;
            TRAINED <= 1'b0;
            if (train_cnt != CNT_MAX) begin
              train_cnt <= train_cnt + CNT_ONE;
            end
          end
        end

        ST_DATA: begin
          OE_DATA <= 4'b1111;
          if (TRAIN_REQ) begin
            state_q   <= ST_TRAIN;
            TX_DATA   <= TRAIN_PATTERN;
            TRAINED   <= 1'b0;
            train_cnt <= CNT_ONE;
          end else begin
            TRAINED <= 1'b1;
            TX_DATA <= USER_VALID ? USER_DATA : IDLE_WORD;
            if (PRBS_EN) begin
              // The word accepted on this edge still has to go out, so the
              // generator is only reseeded here and starts producing on the
              // following edge.
              state_q <= ST_PRBS;
              lfsr    <= PRBS_SEED;
            end
          end
        end

        ST_PRBS: begin
          OE_DATA <= 4'b1111;
          if (TRAIN_REQ) begin
            state_q   <= ST_TRAIN;
            TX_DATA   <= TRAIN_PATTERN;
            TRAINED   <= 1'b0;
            train_cnt <= CNT_ONE;
          end else if (!PRBS_EN) begin
            state_q <= ST_DATA;
            TX_DATA <= IDLE_WORD;
            TRAINED <= 1'b1;
          end else begin
            TX_DATA <= word_from_lfsr;
            lfsr    <= lfsr_after;
            TRAINED <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          TX_DATA <= 8'h00;
          OE_DATA <= 4'b0000;
          TRAINED <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_iod_train_gen.sv
// tb_tx_iod_train_gen
// Table-driven bench for tx_iod_train_gen with TRAIN_CYCLES_MIN=4. Each row
// holds the inputs for one cycle, the expected USER_READY before the edge and
// the expected registered outputs after it. Expected outputs go into a
// scoreboard queue when the row is driven and are popped after the edge.

module tb_tx_iod_train_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       train_req = 1'b0;
  logic       align_done = 1'b0;
  logic       prbs_en = 1'b0;
  logic [7:0] user_data = 8'h00;
  logic       user_valid = 1'b0;
  logic       user_ready;
  logic [7:0] tx_data;
  logic [3:0] oe_data;
  logic [1:0] state;
  logic       trained;

  localparam logic [1:0] S_I = 2'd0;
  localparam logic [1:0] S_T = 2'd1;
  localparam logic [1:0] S_D = 2'd2;
  localparam logic [1:0] S_P = 2'd3;

  typedef struct {
    logic       rst;
    logic       treq;
    logic       align;
    logic       pen;
    logic       uval;
    logic [7:0] udata;
    logic       chk_ready;
    logic       ready;
    logic [1:0] st;
    logic [7:0] tx;
    logic [3:0] oe;
    logic       trained;
  } vec_t;

  typedef struct {
    logic [1:0] st;
    logic [7:0] tx;
    logic [3:0] oe;
    logic       trained;
    int         row;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   passCount = 0;
  int   checkCount = 0;

  always #5 clk = ~clk;

  tx_iod_train_gen #(
    .TRAIN_PATTERN(8'hF0),
    .IDLE_WORD(8'hA5),
    .TRAIN_CYCLES_MIN(4),
    .PRBS_SEED(7'h7F)
  ) dut (
    .FAB_CLK(clk),
    .TX_SYNC_RST(rst),
    .TRAIN_REQ(train_req),
    .ALIGN_DONE(align_done),
    .PRBS_EN(prbs_en),
    .USER_DATA(user_data),
    .USER_VALID(user_valid),
    .USER_READY(user_ready),
    .TX_DATA(tx_data),
    .OE_DATA(oe_data),
    .STATE(state),
    .TRAINED(trained)
  );

  // Appends one cycle's stimulus and expectations to the vector table.
  function automatic void add(input logic r, input logic tq, input logic al, input logic pe,
                              input logic uv, input logic [7:0] ud, input logic ck,
                              input logic rdy, input logic [1:0] st, input logic [7:0] tx,
                              input logic [3:0] oe, input logic tr);
    vec_t v;
    v.rst = r; v.treq = tq; v.align = al; v.pen = pe; v.uval = uv; v.udata = ud;
    v.chk_ready = ck; v.ready = rdy; v.st = st; v.tx = tx; v.oe = oe; v.trained = tr;
    vecs.push_back(v);
  endfunction

  task automatic checkVal(input string name, input int row, input logic [7:0] act,
                          input logic [7:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s row %0d: got %h expected %h", name, row, act, exp);
  endtask

  // Drives one row away from the clock edge, checks the combinational ready
  // and queues the outputs the row should produce after the next edge.
  task automatic applyStimulus(input vec_t v, input int row);
    exp_t e;
    @(negedge clk);
    rst        = v.rst;
    train_req  = v.treq;
    align_done = v.align;
    prbs_en    = v.pen;
    user_valid = v.uval;
    user_data  = v.udata;
    #1;
    if (v.chk_ready) checkVal("user_ready", row, {7'd0, user_ready}, {7'd0, v.ready});
    e.st = v.st; e.tx = v.tx; e.oe = v.oe; e.trained = v.trained; e.row = row;
    sb.push_back(e);
  endtask

  // Waits for the edge, then pops and compares the registered outputs.
  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkCount++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      checkVal("state", e.row, {6'd0, state}, {6'd0, e.st});
      checkVal("tx_data", e.row, tx_data, e.tx);
      checkVal("oe_data", e.row, {4'd0, oe_data}, {4'd0, e.oe});
      checkVal("trained", e.row, {7'd0, trained}, {7'd0, e.trained});
    end
  endtask

  initial begin
    // Reset (first row cannot check ready: state is still unknown), then idle.
    //  rst tq al pe uv data   ck rdy  st   tx     oe    tr
    add(1, 0, 0, 0, 0, 8'h00, 0, 0, S_I, 8'h00, 4'h0, 0);
    add(1, 1, 0, 0, 0, 8'h00, 1, 0, S_I, 8'h00, 4'h0, 0);
    add(0, 0, 0, 0, 0, 8'h00, 1, 0, S_I, 8'h00, 4'h0, 0);
    // Training burst: request pulse, four pattern words, then DATA.
    add(0, 1, 1, 0, 0, 8'h00, 1, 0, S_T, 8'hF0, 4'hF, 0);
    add(0, 0, 1, 0, 0, 8'h00, 1, 0, S_T, 8'hF0, 4'hF, 0);
    add(0, 0, 1, 0, 0, 8'h00, 1, 0, S_T, 8'hF0, 4'hF, 0);
    add(0, 0, 1, 0, 0, 8'h00, 1, 0, S_T, 8'hF0, 4'hF, 0);
    add(0, 0, 1, 0, 0, 8'h00, 1, 0, S_D, 8'hA5, 4'hF, 1);
    // Data path: 0x11, gap, 0x22.
    add(0, 0, 1, 0, 1, 8'h11, 1, 1, S_D, 8'h11, 4'hF, 1);
    add(0, 0, 1, 0, 0, 8'h00, 1, 1, S_D, 8'hA5, 4'hF, 1);
    add(0, 0, 1, 0, 1, 8'h22, 1, 1, S_D, 8'h22, 4'hF, 1);
    // Retrain with a valid word present: not accepted, counter restarts.
    add(0, 1, 1, 0, 1, 8'h33, 1, 0, S_T, 8'hF0, 4'hF, 0);
    add(0, 0, 1, 0, 0, 8'h00, 1, 0, S_T, 8'hF0, 4'hF, 0);
    add(0, 0, 1, 0, 0, 8'h00, 1, 0, S_T, 8'hF0, 4'hF, 0);
    add(0, 0, 1, 0, 0, 8'h00, 1, 0, S_T, 8'hF0, 4'hF, 0);
    // Exit into PRBS from seed 7F: 7F, 20; then back to DATA.
    add(0, 0, 1, 1, 0, 8'h00, 1, 0, S_P, 8'h7F, 4'hF, 1);
    add(0, 0, 1, 1, 0, 8'h00, 1, 0, S_P, 8'h20, 4'hF, 1);
    add(0, 0, 1, 0, 0, 8'h00, 1, 0, S_D, 8'hA5, 4'hF, 1);
    // PRBS_EN rises in DATA with a word: word goes out, PRBS restarts from seed.
    add(0, 0, 1, 1, 1, 8'h5A, 1, 1, S_P, 8'h5A, 4'hF, 1);
    add(0, 0, 1, 1, 0, 8'h00, 1, 0, S_P, 8'h7F, 4'hF, 1);
    add(0, 0, 1, 1, 0, 8'h00, 1, 0, S_P, 8'h20, 4'hF, 1);
    // Retrain from PRBS with alignment low; counter saturates then stalls.
    add(0, 1, 0, 1, 0, 8'h00, 1, 0, S_T, 8'hF0, 4'hF, 0);
    for (int i = 0; i < 3 + 10; i++) begin
      add(0, 0, 0, 0, 0, 8'h00, 1, 0, S_T, 8'hF0, 4'hF, 0);
    end
    add(0, 0, 1, 0, 0, 8'h00, 1, 0, S_D, 8'hA5, 4'hF, 1);
    // TRAIN_REQ held high in TRAIN keeps counting: 4 pattern words total.
    add(0, 1, 1, 0, 0, 8'h00, 1, 0, S_T, 8'hF0, 4'hF, 0);
    add(0, 1, 1, 0, 0, 8'h00, 1, 0, S_T, 8'hF0, 4'hF, 0);
    add(0, 1, 1, 0, 0, 8'h00, 1, 0, S_T, 8'hF0, 4'hF, 0);
    add(0, 0, 1, 0, 0, 8'h00, 1, 0, S_T, 8'hF0, 4'hF, 0);
    add(0, 0, 1, 0, 0, 8'h00, 1, 0, S_D, 8'hA5, 4'hF, 1);
    // Two-cycle reset mid-DATA dominates valid data and a train request.
    add(1, 0, 1, 0, 1, 8'h77, 1, 1, S_I, 8'h00, 4'h0, 0);
    add(1, 1, 1, 1, 1, 8'h77, 1, 0, S_I, 8'h00, 4'h0, 0);
    add(0, 0, 0, 0, 0, 8'h00, 1, 0, S_I, 8'h00, 4'h0, 0);

    for (int r = 0; r < vecs.size(); r++) begin
      applyStimulus(vecs[r], r);
      checkOutput();
    end

    if (sb.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
